// File: rtl/bp_me_mem_cmd_arbiter.sv
// Shares one bp_mem command/response port between num_req_p requesters: round-robin on
// commands, in-order responses routed back through a requester-ID FIFO.
module bp_me_mem_cmd_arbiter #(
    parameter int unsigned num_req_p         = 2,
    parameter int unsigned msg_width_p       = 128,
    parameter int unsigned max_outstanding_p = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_i,

    input  logic [num_req_p*msg_width_p-1:0] mem_cmd_i,
    input  logic [num_req_p-1:0]             mem_cmd_v_i,
    output logic [num_req_p-1:0]             mem_cmd_yumi_o,

    output logic [msg_width_p-1:0]           mem_resp_o,
    output logic [num_req_p-1:0]             mem_resp_v_o,
    input  logic [num_req_p-1:0]             mem_resp_ready_i,

    output logic [msg_width_p-1:0]           mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_ready_i,

    input  logic [msg_width_p-1:0]           mem_resp_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_yumi_o
);

    localparam int unsigned IdWidth  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int unsigned CntWidth = $clog2(max_outstanding_p + 1);
    localparam int unsigned PtrWidth = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

    localparam logic [CntWidth-1:0] CntMax  = CntWidth'(max_outstanding_p);
    localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(max_outstanding_p - 1);
    localparam logic [IdWidth-1:0]  IdLast  = IdWidth'(num_req_p - 1);

    logic [IdWidth-1:0]  prio_q, prio_d;
    logic [IdWidth-1:0]  winner;
    logic [IdWidth-1:0]  head;
    logic                any_v;
    logic                credit;
    logic                empty;
    logic                cmd_v;
    logic                resp_v;
    logic                push;
    logic                pop;
    int unsigned         idx;

    logic [IdWidth-1:0]  id_mem_q [max_outstanding_p];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;

    // Round-robin search starting at the priority pointer, wrapping past the last requester.
    always_comb begin
        winner = prio_q;
        any_v  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            idx = (32'(prio_q) + i) % num_req_p;
            if (!any_v && mem_cmd_v_i[idx]) begin
                winner = IdWidth'(idx);
                any_v  = 1'b1;
            end
        end
    end

    always_comb begin
        credit = (count_q < CntMax);
        empty  = (count_q == '0);
        head   = id_mem_q[rd_ptr_q];

        cmd_v  = any_v & credit & ~reset_i;
        push   = cmd_v & mem_cmd_ready_i;
        resp_v = mem_resp_v_i & ~empty & ~reset_i;
        pop    = resp_v & mem_resp_ready_i[head];

        mem_cmd_v_o     = cmd_v;
        mem_cmd_o       = mem_cmd_i[32'(winner)*msg_width_p +: msg_width_p];
        mem_cmd_yumi_o  = push ? (num_req_p'(1) << winner) : '0;

        mem_resp_o      = mem_resp_i;
        mem_resp_v_o    = resp_v ? (num_req_p'(1) << head) : '0;
        mem_resp_yumi_o = pop;
    end

    always_comb begin
        prio_d   = prio_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            prio_d   = (winner == IdLast) ? '0 : winner + 1'b1;
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prio_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            prio_q   <= prio_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                id_mem_q[wr_ptr_q] <= winner;
            end
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding means the memory side produced an unrequested reply.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(mem_resp_v_i && empty))
            else $error("bp_me_mem_cmd_arbiter: mem_resp_v_i with no outstanding command");
        end
    end
`endif

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Bench for bp_me_mem_cmd_arbiter: directed scenarios plus random traffic, all checked against
// a queue-based model of issued-but-unanswered commands.
module tb_bp_me_mem_cmd_arbiter;

    localparam int N   = 2;
    localparam int W   = 128;
    localparam int Max = 4;

    logic           clk = 1'b0;
    logic           reset_i;
    logic [N*W-1:0] mem_cmd_i;
    logic [N-1:0]   mem_cmd_v_i;
    logic [N-1:0]   mem_cmd_yumi_o;
    logic [W-1:0]   mem_resp_o;
    logic [N-1:0]   mem_resp_v_o;
    logic [N-1:0]   mem_resp_ready_i;
    logic [W-1:0]   mem_cmd_o;
    logic           mem_cmd_v_o;
    logic           mem_cmd_ready_i;
    logic [W-1:0]   mem_resp_i;
    logic           mem_resp_v_i;
    logic           mem_resp_yumi_o;

    always #5 clk = ~clk;

    bp_me_mem_cmd_arbiter #(
        .num_req_p        (N),
        .msg_width_p      (W),
        .max_outstanding_p(Max)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .mem_cmd_i       (mem_cmd_i),
        .mem_cmd_v_i     (mem_cmd_v_i),
        .mem_cmd_yumi_o  (mem_cmd_yumi_o),
        .mem_resp_o      (mem_resp_o),
        .mem_resp_v_o    (mem_resp_v_o),
        .mem_resp_ready_i(mem_resp_ready_i),
        .mem_cmd_o       (mem_cmd_o),
        .mem_cmd_v_o     (mem_cmd_v_o),
        .mem_cmd_ready_i (mem_cmd_ready_i),
        .mem_resp_i      (mem_resp_i),
        .mem_resp_v_i    (mem_resp_v_i),
        .mem_resp_yumi_o (mem_resp_yumi_o)
    );

    typedef struct {
        int           id;
        logic [W-1:0] data;
    } ent_t;

    ent_t q[$];     // outstanding commands, oldest first
    int   ptr;      // round-robin start point
    int   checks;
    int   failures;

    logic [N-1:0] last_yumi, last_rv;
    logic         last_cv, last_ry;

    task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_msg();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: drive inputs, compare against the model mid-cycle, then advance the model.
    task automatic step(input logic rst, input logic [N-1:0] v, input logic cr,
                        input logic rv, input logic [N-1:0] rr);
        logic [W-1:0] msgs[N];
        logic [W-1:0] rdata;
        logic [N-1:0] e_yumi, e_rv;
        logic         e_cv, e_ry;
        int           win;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            msgs[k] = rand_msg();
            mem_cmd_i[k*W +: W] = msgs[k];
        end
        // Memory echoes the inverted command of the oldest outstanding request.
        rdata            = (q.size() > 0) ? ~q[0].data : rand_msg();
        reset_i          = rst;
        mem_cmd_v_i      = v;
        mem_cmd_ready_i  = cr;
        mem_resp_v_i     = rv;
        mem_resp_i       = rdata;
        mem_resp_ready_i = rr;
        #1;
        win = -1;
        for (int i = 0; i < N; i++) begin
            if (win < 0 && v[(ptr + i) % N]) win = (ptr + i) % N;
        end
        e_cv   = !rst && (win >= 0) && (q.size() < Max);
        e_yumi = (e_cv && cr) ? (N'(1) << win) : '0;
        e_rv   = '0;
        e_ry   = 1'b0;
        if (!rst && q.size() > 0 && rv) begin
            e_rv = N'(1) << q[0].id;
            e_ry = rr[q[0].id];
        end
        check_eq("cmd_v", W'(mem_cmd_v_o), W'(e_cv));
        check_eq("cmd_yumi", W'(mem_cmd_yumi_o), W'(e_yumi));
        if (e_cv) check_eq("cmd_data", mem_cmd_o, msgs[win]);
        check_eq("resp_v", W'(mem_resp_v_o), W'(e_rv));
        check_eq("resp_yumi", W'(mem_resp_yumi_o), W'(e_ry));
        if (e_ry) check_eq("resp_data", mem_resp_o, ~q[0].data);
        last_yumi = mem_cmd_yumi_o;
        last_cv   = mem_cmd_v_o;
        last_rv   = mem_resp_v_o;
        last_ry   = mem_resp_yumi_o;
        @(posedge clk);
        if (rst) begin
            q.delete();
            ptr = 0;
        end else begin
            if (e_ry) void'(q.pop_front());
            if (e_yumi != '0) begin
                q.push_back('{id: win, data: msgs[win]});
                ptr = (win + 1) % N;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ptr      = 0;
        step(1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
        step(1'b1, 2'b11, 1'b1, 1'b0, 2'b11);
        check_eq("reset_cmd_v", W'(last_cv), W'(1'b0));

        // Alternating grants until credits run out.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b11, 1'b1, 1'b0, 2'b00);
            check_eq("rr_grant", W'(last_yumi), (i % 2 == 0) ? W'(2'b01) : W'(2'b10));
        end
        step(1'b0, 2'b11, 1'b1, 1'b0, 2'b00);
        check_eq("credit_full", W'(last_cv), W'(1'b0));
        step(1'b0, 2'b11, 1'b1, 1'b1, 2'b11);
        check_eq("no_bypass", W'(last_cv), W'(1'b0));
        check_eq("pop_head0", W'(last_rv), W'(2'b01));
        step(1'b0, 2'b11, 1'b1, 1'b0, 2'b00);
        check_eq("credit_back", W'(last_yumi), W'(2'b01));

        // Drain in order: 1,0,1,0.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b00, 1'b1, 1'b1, 2'b11);
            check_eq("drain_order", W'(last_rv), (i % 2 == 0) ? W'(2'b10) : W'(2'b01));
        end

        // Non-ready head blocks the response behind it.
        step(1'b0, 2'b01, 1'b1, 1'b0, 2'b00);
        step(1'b0, 2'b10, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'b00, 1'b1, 1'b1, 2'b10);
            check_eq("head_block", W'(last_ry), W'(1'b0));
        end
        step(1'b0, 2'b00, 1'b1, 1'b1, 2'b11);
        check_eq("head_release", W'(last_rv), W'(2'b01));
        step(1'b0, 2'b00, 1'b1, 1'b1, 2'b11);
        check_eq("second_resp", W'(last_rv), W'(2'b10));

        // Stalled memory: requester 1 keeps waiting, then is consumed.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b10, 1'b0, 1'b0, 2'b00);
            check_eq("stall_v", W'(last_cv), W'(1'b1));
            check_eq("stall_yumi", W'(last_yumi), W'(2'b00));
        end
        step(1'b0, 2'b10, 1'b1, 1'b0, 2'b00);
        check_eq("stall_done", W'(last_yumi), W'(2'b10));

        // Reset with two outstanding and a stray response in flight.
        step(1'b0, 2'b01, 1'b1, 1'b0, 2'b00);
        step(1'b1, 2'b11, 1'b1, 1'b1, 2'b11);
        check_eq("rst_resp_v", W'(last_rv), W'(2'b00));
        check_eq("rst_resp_yumi", W'(last_ry), W'(1'b0));
        step(1'b0, 2'b11, 1'b1, 1'b0, 2'b11);
        check_eq("post_rst_grant", W'(last_yumi), W'(2'b01));

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) == 0),
                 N'($urandom),
                 ($urandom_range(0, 3) != 0),
                 (q.size() > 0) && ($urandom_range(0, 2) != 0),
                 N'($urandom) | N'(($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
